// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one memory port between the instruction fetch unit
// and the load/store unit. One transaction in flight at a time. LSU wins
// contention until the IFU has been passed over STARVE_LIMIT times in a row.
module mem_port_arb #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DATA_BYTE    = DATA_WIDTH / 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction fetch requester
  input  logic                  ifu_req_vld,
  output logic                  ifu_req_rdy,
  input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
  input  logic                  ifu_flush,
  output logic                  ifu_rsp_vld,
  output logic [DATA_WIDTH-1:0] ifu_rsp_data,
  // load/store requester
  input  logic                  lsu_req_vld,
  output logic                  lsu_req_rdy,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic [DATA_WIDTH-1:0] lsu_req_data,
  input  logic [DATA_BYTE-1:0]  lsu_req_data_strobe,
  output logic                  lsu_rsp_vld,
  output logic [DATA_WIDTH-1:0] lsu_rsp_data,
  // shared memory port
  output logic                  mem_req_vld,
  input  logic                  mem_req_rdy,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_data,
  output logic [DATA_BYTE-1:0]  mem_req_strobe,
  input  logic                  mem_rsp_vld,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] starve_cnt_reg;
  logic             drop_reg;
  logic             owner_reg;   // 1 = LSU owns the in-flight transaction, 0 = IFU
  logic             grant_lsu;
  logic             grant_ifu;
  logic             rsp_done;

  // The memory response closes the transaction only while waiting for it.
  assign rsp_done = (state_reg == WAIT) && mem_rsp_vld;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic, combinational grant and request-side handshakes.
  always_comb begin
    state_next  = state_reg;
    ifu_req_rdy = 1'b0;
    lsu_req_rdy = 1'b0;
    mem_req_vld = 1'b0;
    // LSU wins unless the IFU has been starved to the limit while waiting.
    grant_lsu   = lsu_req_vld && !(ifu_req_vld && (starve_cnt_reg == LIMIT));
    grant_ifu   = ifu_req_vld && !grant_lsu;
    case (state_reg)
      IDLE: begin
        lsu_req_rdy = grant_lsu;
        ifu_req_rdy = grant_ifu;
        if (grant_lsu || grant_ifu) begin
          state_next = REQ;
        end
      end
      REQ: begin
        mem_req_vld = 1'b1;
        if (mem_req_rdy) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_vld) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the granted request so the memory port sees stable fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_addr   <= '0;
      mem_req_data   <= '0;
      mem_req_strobe <= '0;
      owner_reg      <= 1'b0;
    end else if (lsu_req_rdy) begin
      mem_req_addr   <= lsu_req_addr;
      mem_req_data   <= lsu_req_data;
      mem_req_strobe <= lsu_req_data_strobe;
      owner_reg      <= 1'b1;
    end else if (ifu_req_rdy) begin
      mem_req_addr   <= ifu_req_addr;
      mem_req_data   <= '0;
      mem_req_strobe <= '0;
      owner_reg      <= 1'b0;
    end
  end

  // Count LSU grants that bypassed a waiting IFU; an IFU grant resets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else if (ifu_req_rdy) begin
      starve_cnt_reg <= '0;
    end else if (lsu_req_rdy && ifu_req_vld && (starve_cnt_reg != LIMIT)) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

  // Remember a flush of an in-flight fetch so its response is swallowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_reg <= 1'b0;
    end else if (rsp_done) begin
      drop_reg <= 1'b0;
    end else if (ifu_flush && !owner_reg && (state_reg != IDLE)) begin
      drop_reg <= 1'b1;
    end
  end

  // Route the memory response to its owner as a one-cycle registered pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifu_rsp_vld  <= 1'b0;
      ifu_rsp_data <= '0;
      lsu_rsp_vld  <= 1'b0;
      lsu_rsp_data <= '0;
    end else begin
      // A flush arriving together with the response still suppresses it.
      ifu_rsp_vld <= rsp_done && !owner_reg && !drop_reg && !ifu_flush;
      lsu_rsp_vld <= rsp_done && owner_reg;
      if (rsp_done && !owner_reg && !drop_reg && !ifu_flush) begin
        ifu_rsp_data <= mem_rsp_data;
      end
      if (rsp_done && owner_reg) begin
        lsu_rsp_data <= mem_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: a behavioural memory with adjustable latency,
// a response scoreboard, and one task per scenario.
module tb_mem_port_arb;

  logic        clk;
  logic        rst;
  logic        ifu_req_vld;
  logic        ifu_req_rdy;
  logic [31:0] ifu_req_addr;
  logic        ifu_flush;
  logic        ifu_rsp_vld;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_vld;
  logic        lsu_req_rdy;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_data;
  logic [3:0]  lsu_req_data_strobe;
  logic        lsu_rsp_vld;
  logic [31:0] lsu_rsp_data;
  logic        mem_req_vld;
  logic        mem_req_rdy;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_strobe;
  logic        mem_rsp_vld;
  logic [31:0] mem_rsp_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_lsu;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;
  exp_t sb_q[$];

  // memory model state
  int          rsp_lat = 1;
  bit          mem_acc;
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_pdata;

  mem_port_arb #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .DATA_BYTE   (4),
    .STARVE_LIMIT(4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ifu_req_vld        (ifu_req_vld),
    .ifu_req_rdy        (ifu_req_rdy),
    .ifu_req_addr       (ifu_req_addr),
    .ifu_flush          (ifu_flush),
    .ifu_rsp_vld        (ifu_rsp_vld),
    .ifu_rsp_data       (ifu_rsp_data),
    .lsu_req_vld        (lsu_req_vld),
    .lsu_req_rdy        (lsu_req_rdy),
    .lsu_req_addr       (lsu_req_addr),
    .lsu_req_data       (lsu_req_data),
    .lsu_req_data_strobe(lsu_req_data_strobe),
    .lsu_rsp_vld        (lsu_rsp_vld),
    .lsu_rsp_data       (lsu_rsp_data),
    .mem_req_vld        (mem_req_vld),
    .mem_req_rdy        (mem_req_rdy),
    .mem_req_addr       (mem_req_addr),
    .mem_req_data       (mem_req_data),
    .mem_req_strobe     (mem_req_strobe),
    .mem_rsp_vld        (mem_rsp_vld),
    .mem_rsp_data       (mem_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory: accepts when vld&rdy, answers rsp_lat cycles later.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      mem_acc     = 1'b0;
      mem_pend    = 1'b0;
      mem_cnt     = 0;
      mem_rsp_vld = 1'b0;
    end else begin
      mem_rsp_vld = 1'b0;
      if (mem_acc) begin
        mem_pend = 1'b1;
        mem_cnt  = rsp_lat - 1;
      end
      if (mem_pend) begin
        if (mem_cnt == 0) begin
          mem_rsp_vld  = 1'b1;
          mem_rsp_data = mem_pdata;
          mem_pend     = 1'b0;
        end else begin
          mem_cnt = mem_cnt - 1;
        end
      end
      mem_acc = mem_req_vld && mem_req_rdy;
      if (mem_acc) mem_pdata = mem_word(mem_req_addr);
    end
  end

  // Response monitor: every pulse must match the head of the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && (ifu_rsp_vld || lsu_rsp_vld)) begin
      checks++;
      if (ifu_rsp_vld && lsu_rsp_vld) begin
        errors++;
        $display("FAIL rsp_both ifu_rsp_vld=%b lsu_rsp_vld=%b expected one", ifu_rsp_vld, lsu_rsp_vld);
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected ifu_rsp_vld=%b lsu_rsp_vld=%b expected none", ifu_rsp_vld, lsu_rsp_vld);
      end else begin
        e = sb_q.pop_front();
        if (lsu_rsp_vld !== e.is_lsu) begin
          errors++;
          $display("FAIL rsp_owner got lsu=%b expected lsu=%b", lsu_rsp_vld, e.is_lsu);
        end else if (e.chk_data && ((e.is_lsu ? lsu_rsp_data : ifu_rsp_data) !== e.data)) begin
          errors++;
          $display("FAIL rsp_data got %h expected %h", e.is_lsu ? lsu_rsp_data : ifu_rsp_data, e.data);
        end else begin
          $display("rsp %s data=%h ok", e.is_lsu ? "lsu" : "ifu", e.is_lsu ? lsu_rsp_data : ifu_rsp_data);
        end
      end
    end
  end

  task automatic ifu_issue(input logic [31:0] a, input bit exp);
    int n = 0;
    @(negedge clk);
    ifu_req_vld  = 1'b1;
    ifu_req_addr = a;
    #1;
    while (ifu_req_rdy !== 1'b1 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (ifu_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL ifu_grant_timeout addr=%h rdy=%b expected 1", a, ifu_req_rdy);
    end else if (exp) begin
      sb_q.push_back('{1'b0, mem_word(a), 1'b1});
    end
    $display("ifu req addr=%h", a);
    @(negedge clk);
    ifu_req_vld = 1'b0;
  endtask

  task automatic lsu_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    lsu_req_vld         = 1'b1;
    lsu_req_addr        = a;
    lsu_req_data        = d;
    lsu_req_data_strobe = s;
    #1;
    while (lsu_req_rdy !== 1'b1 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (lsu_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL lsu_grant_timeout addr=%h rdy=%b expected 1", a, lsu_req_rdy);
    end else begin
      sb_q.push_back('{1'b1, mem_word(a), (s == 4'h0)});
    end
    $display("lsu req addr=%h data=%h strobe=%h", a, d, s);
    @(negedge clk);
    lsu_req_vld = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (12) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Minimum-latency fetch with cycle-exact checks (memory latency 1).
  task automatic fetch_timed(input logic [31:0] a, input string name);
    logic [31:0] d;
    d = mem_word(a);
    @(negedge clk);
    ifu_req_vld  = 1'b1;
    ifu_req_addr = a;
    sb_q.push_back('{1'b0, d, 1'b1});
    #1;
    checks++;
    if (ifu_req_rdy !== 1'b1 || lsu_req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL %s_c0 ifu_rdy=%b lsu_rdy=%b expected 1 0", name, ifu_req_rdy, lsu_req_rdy);
    end
    @(negedge clk);
    ifu_req_vld = 1'b0;
    #1;
    checks++;
    if (mem_req_vld !== 1'b1 || mem_req_addr !== a || mem_req_strobe !== 4'h0 || mem_req_data !== 32'h0) begin
      errors++;
      $display("FAIL %s_c1 vld=%b addr=%h strb=%h data=%h expected 1 %h 0 0", name,
               mem_req_vld, mem_req_addr, mem_req_strobe, mem_req_data, a);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_req_vld !== 1'b0 || ifu_rsp_vld !== 1'b0) begin
      errors++;
      $display("FAIL %s_c2 mem_req_vld=%b ifu_rsp_vld=%b expected 0 0", name, mem_req_vld, ifu_rsp_vld);
    end
    @(negedge clk); #1;
    checks++;
    if (ifu_rsp_vld !== 1'b1 || ifu_rsp_data !== d || lsu_rsp_vld !== 1'b0) begin
      errors++;
      $display("FAIL %s_c3 ifu_rsp_vld=%b data=%h lsu_rsp_vld=%b expected 1 %h 0", name,
               ifu_rsp_vld, ifu_rsp_data, lsu_rsp_vld, d);
    end
    @(negedge clk); #1;
    checks++;
    if (ifu_rsp_vld !== 1'b0) begin
      errors++;
      $display("FAIL %s_c4 ifu_rsp_vld=%b expected 0", name, ifu_rsp_vld);
    end
    $display("%s fetch addr=%h done", name, a);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({ifu_req_rdy, lsu_req_rdy, mem_req_vld, ifu_rsp_vld, lsu_rsp_vld, mem_req_addr,
         mem_req_data, mem_req_strobe, ifu_rsp_data, lsu_rsp_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs addr=%h data=%h strb=%h mem_vld=%b expected all 0",
               mem_req_addr, mem_req_data, mem_req_strobe, mem_req_vld);
    end
    checks++;
    if (dut.starve_cnt_reg !== '0 || dut.drop_reg !== 1'b0 || dut.owner_reg !== 1'b0) begin
      errors++;
      $display("FAIL reset_state starve=%0d drop=%b owner=%b expected 0 0 0",
               dut.starve_cnt_reg, dut.drop_reg, dut.owner_reg);
    end
    $display("reset checked");
    rst = 1'b0;
  endtask

  task automatic test_ifu_fetch();
    fetch_timed(32'h100, "ifu_fetch");
    drain("ifu_fetch");
  endtask

  task automatic test_lsu_store();
    int pulses = 0;
    lsu_issue(32'h200, 32'h12345678, 4'h3);
    #1;
    checks++;
    if (mem_req_vld !== 1'b1 || mem_req_addr !== 32'h200 || mem_req_data !== 32'h12345678 || mem_req_strobe !== 4'h3) begin
      errors++;
      $display("FAIL store_req vld=%b addr=%h data=%h strb=%h expected 1 200 12345678 3",
               mem_req_vld, mem_req_addr, mem_req_data, mem_req_strobe);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (lsu_rsp_vld === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL store_ack_pulses got %0d expected 1", pulses);
    end
    drain("lsu_store");
  endtask

  task automatic test_back_pressure();
    int n = 0;
    mem_req_rdy = 1'b0;
    lsu_issue(32'h300, 32'hAAAA5555, 4'h0);
    ifu_req_vld  = 1'b1;
    ifu_req_addr = 32'h400;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (mem_req_vld !== 1'b1 || mem_req_addr !== 32'h300 || ifu_req_rdy !== 1'b0 || lsu_req_rdy !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d vld=%b addr=%h ifu_rdy=%b lsu_rdy=%b expected 1 300 0 0",
                 i, mem_req_vld, mem_req_addr, ifu_req_rdy, lsu_req_rdy);
      end
      $display("stall cycle %0d vld=%b addr=%h", i, mem_req_vld, mem_req_addr);
      @(negedge clk);
    end
    mem_req_rdy = 1'b1;
    #1;
    while (ifu_req_rdy !== 1'b1 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (ifu_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL stall_ifu_grant rdy=%b expected 1", ifu_req_rdy);
    end else begin
      sb_q.push_back('{1'b0, mem_word(32'h400), 1'b1});
    end
    @(negedge clk);
    ifu_req_vld = 1'b0;
    drain("back_pressure");
  endtask

  task automatic test_starvation();
    int  grants = 0;
    int  n      = 0;
    bit  chk_cnt = 1'b0;
    bit  bump    = 1'b0;
    bit  exp_ifu;
    @(negedge clk);
    lsu_req_vld         = 1'b1;
    lsu_req_addr        = 32'h1000;
    lsu_req_data        = 32'h0;
    lsu_req_data_strobe = 4'h0;
    ifu_req_vld         = 1'b1;
    ifu_req_addr        = 32'h2000;
    while (grants < 10 && n < 300) begin
      if (bump) lsu_req_addr = lsu_req_addr + 32'h4;
      bump = 1'b0;
      #1;
      if (chk_cnt) begin
        chk_cnt = 1'b0;
        checks++;
        if (dut.starve_cnt_reg !== '0) begin
          errors++;
          $display("FAIL starve_cnt_after_ifu got %0d expected 0", dut.starve_cnt_reg);
        end
      end
      if (ifu_req_rdy === 1'b1 || lsu_req_rdy === 1'b1) begin
        exp_ifu = ((grants % 5) == 4);
        checks++;
        if (ifu_req_rdy !== exp_ifu || lsu_req_rdy !== !exp_ifu) begin
          errors++;
          $display("FAIL starve_grant%0d ifu_rdy=%b lsu_rdy=%b expected ifu=%b", grants,
                   ifu_req_rdy, lsu_req_rdy, exp_ifu);
        end
        if (ifu_req_rdy === 1'b1) begin
          sb_q.push_back('{1'b0, mem_word(ifu_req_addr), 1'b1});
          chk_cnt = 1'b1;
        end else begin
          sb_q.push_back('{1'b1, mem_word(lsu_req_addr), 1'b1});
          bump = 1'b1;
        end
        $display("starve grant %0d -> %s", grants, ifu_req_rdy ? "ifu" : "lsu");
        grants++;
      end
      @(negedge clk);
      n++;
    end
    lsu_req_vld = 1'b0;
    ifu_req_vld = 1'b0;
    checks++;
    if (grants != 10) begin
      errors++;
      $display("FAIL starve_timeout grants=%0d expected 10", grants);
    end
    drain("starvation");
  endtask

  task automatic test_flush();
    int n = 0;
    bit prev = 1'b0;
    bit saw_ifu = 1'b0;
    bit got = 1'b0;
    rsp_lat = 3;
    // flush during the fetch, LSU waiting behind it
    ifu_issue(32'h500, 1'b0);
    @(negedge clk);
    ifu_flush           = 1'b1;
    lsu_req_vld         = 1'b1;
    lsu_req_addr        = 32'h600;
    lsu_req_data_strobe = 4'h0;
    @(negedge clk);
    ifu_flush = 1'b0;
    while (n < 50) begin
      #1;
      if (ifu_rsp_vld === 1'b1) saw_ifu = 1'b1;
      if (lsu_req_rdy === 1'b1) begin
        got = 1'b1;
        break;
      end
      prev = mem_rsp_vld;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!got || !prev) begin
      errors++;
      $display("FAIL flush_lsu_grant got=%b after_rsp=%b expected 1 1", got, prev);
    end
    checks++;
    if (saw_ifu) begin
      errors++;
      $display("FAIL flush_suppress ifu_rsp_vld=1 expected 0");
    end
    if (got) sb_q.push_back('{1'b1, mem_word(32'h600), 1'b1});
    $display("flush fetch 500 dropped, lsu 600 granted");
    @(negedge clk);
    lsu_req_vld = 1'b0;
    drain("flush");
    // flush coinciding with the memory response
    n = 0;
    ifu_issue(32'h504, 1'b0);
    while (n < 50) begin
      @(negedge clk); #1; n++;
      if (mem_rsp_vld === 1'b1) begin
        ifu_flush = 1'b1;
        break;
      end
    end
    @(negedge clk);
    ifu_flush = 1'b0;
    #1;
    checks++;
    if (ifu_rsp_vld !== 1'b0 || n >= 50) begin
      errors++;
      $display("FAIL flush_same_cycle ifu_rsp_vld=%b waited=%0d expected 0", ifu_rsp_vld, n);
    end
    $display("flush same-cycle fetch 504 dropped");
    drain("flush_same");
    // flush while the LSU owns the port has no effect
    lsu_issue(32'h508, 32'h0, 4'h0);
    ifu_flush = 1'b1;
    drain("flush_lsu");
    ifu_flush = 1'b0;
    rsp_lat = 1;
  endtask

  task automatic test_reset_in_wait();
    int pulses = 0;
    rsp_lat = 4;
    ifu_issue(32'h700, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req_vld !== 1'b0 || ifu_req_rdy !== 1'b0 || lsu_req_rdy !== 1'b0 || mem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_wait vld=%b ifu_rdy=%b lsu_rdy=%b addr=%h expected 0 0 0 0",
               mem_req_vld, ifu_req_rdy, lsu_req_rdy, mem_req_addr);
    end
    @(negedge clk);
    rst     = 1'b0;
    rsp_lat = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ifu_rsp_vld === 1'b1 || lsu_rsp_vld === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_rsp pulses=%0d expected 0", pulses);
    end
    $display("reset in wait abandoned fetch 700");
    fetch_timed(32'h704, "after_reset");
    drain("after_reset");
  endtask

  initial begin
    ifu_req_vld         = 1'b0;
    ifu_req_addr        = 32'h0;
    ifu_flush           = 1'b0;
    lsu_req_vld         = 1'b0;
    lsu_req_addr        = 32'h0;
    lsu_req_data        = 32'h0;
    lsu_req_data_strobe = 4'h0;
    mem_req_rdy         = 1'b1;
    mem_rsp_data        = 32'h0;
    test_reset();
    test_ifu_fetch();
    test_lsu_store();
    test_back_pressure();
    test_starvation();
    test_flush();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
